frame_sync_ctrl: RTL

Video-timing controller placed directly after the HDMI input, ahead of the rgb2y and SGM datapath stages. It tracks pixel and line position from de/hsync/vsync and locks onto whole frames. Pixels are forwarded only while locked. A datapath mode word is applied only at frame boundaries, so downstream stages never switch configuration mid-frame.

---
 rtl/frame_sync_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/frame_sync_ctrl.sv
// Video-timing front end: tracks pixel/line position from de/hsync/vsync, locks onto
// whole frames, forwards pixels only while locked and switches datapath mode at vsync.
module frame_sync_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           de_in,
    input  logic           h_sync_in,
    input  logic           v_sync_in,
    input  logic [1:0]     mode_req,
    input  logic           mode_req_valid,
    output logic           de_out,
    output logic           h_sync_out,
    output logic           v_sync_out,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           sol,
    output logic           eol,
    output logic           sof,
    output logic           eof,
    output logic           locked,
    output logic           frame_err,
    output logic [1:0]     mode_active,
    output logic [15:0]    frame_cnt
);

    // state    | meaning
    // UNLOCKED | no frame reference yet (or timing broke); pixels dropped until vsync
    // LOCKED   | frame timing tracked and checked; pixels forwarded
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

    state_t         state_q;
    state_t         state_d;
    logic           de_q;
    logic           vs_q;
    logic [X_W-1:0] xc;
    logic [Y_W-1:0] yc;
    logic [1:0]     mode_pend;

    logic vs_rise;
    logic de_rise;
    logic de_fall;
    logic line_long;
    logic line_short;
    logic lines_extra;
    logic viol;
    logic err_d;
    logic frame_good;
    logic pix_fwd;

    assign vs_rise     = v_sync_in & ~vs_q;
    assign de_rise     = de_in & ~de_q;
    assign de_fall     = ~de_in & de_q;
    assign line_long   = de_in & (xc == X_MAX);
    assign line_short  = de_fall & (xc != X_MAX);
    assign lines_extra = de_rise & (yc == Y_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        viol       = 1'b0;
        err_d      = 1'b0;
        frame_good = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (vs_rise) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                viol = line_long | line_short | lines_extra;
                if (viol) begin
                    state_d = UNLOCKED;
                    err_d   = 1'b1;
                end else if (vs_rise) begin
                    // a short frame is reported but keeps lock; only complete frames count
                    frame_good = (yc == Y_MAX);
                    err_d      = (yc != Y_MAX);
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    assign locked  = (state_q == LOCKED);
    assign pix_fwd = de_in & locked & ~viol;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_q        <= 1'b0;
            vs_q        <= 1'b0;
            xc          <= '0;
            yc          <= '0;
            mode_pend   <= 2'd0;
            de_out      <= 1'b0;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            sol         <= 1'b0;
            eol         <= 1'b0;
            sof         <= 1'b0;
            eof         <= 1'b0;
            frame_err   <= 1'b0;
            mode_active <= 2'd0;
            frame_cnt   <= 16'd0;
        end else begin
            de_q <= de_in;
            vs_q <= v_sync_in;

            // saturation keeps garbage input from wrapping the counters while unlocked
            if (de_in) begin
                if (xc != X_MAX) begin
                    xc <= xc + X_ONE;
                end
            end else if (de_fall) begin
                xc <= '0;
            end

            if (vs_rise) begin
                yc <= '0;
            end else if (de_fall && (yc != Y_MAX)) begin
                yc <= yc + Y_ONE;
            end

            de_out     <= pix_fwd;
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
            x_pos      <= xc;
            y_pos      <= yc;
            sol        <= pix_fwd & (xc == '0);
            eol        <= pix_fwd & (xc == X_LAST);
            sof        <= pix_fwd & (xc == '0) & (yc == '0);
            eof        <= pix_fwd & (xc == X_LAST) & (yc == Y_LAST);
            frame_err  <= err_d;

            if (frame_good) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (mode_req_valid) begin
                mode_pend <= mode_req;
            end
            if (vs_rise) begin
                mode_active <= mode_req_valid ? mode_req : mode_pend;
            end
        end
    end

endmodule
